// File: rtl/mul_share_arb.sv
// mul_share_arb: shares one pipelined multiplier between N requesters.
// A round-robin arbiter picks one requester per cycle. Its operands are
// registered into the multiplier, and its index goes into an in-order tag FIFO.
// Each product that comes back pops the head tag, and the product is strobed
// to that requester one cycle later.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   req[N]             per-requester request, held with operands until granted
//   req_x/req_y[N*W]   flattened operands, requester i at [i*W +: W]
//   gnt[N]             combinational one-hot grant
//   rsp_vld[N]         one-hot single-cycle response strobe
//   rsp_p[2W]          product accompanying rsp_vld
//   mul_vld_in, mul_x, mul_y   registered issue to the multiplier
//   mul_p, mul_vld_out         product return from the multiplier
//   busy               any multiply outstanding
//   err                sticky: product returned with no outstanding tag
module mul_share_arb #(
    parameter int N     = 4,
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   req_x,
    input  logic [N*W-1:0]   req_y,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     rsp_vld,
    output logic [2*W-1:0]   rsp_p,
    output logic             mul_vld_in,
    output logic [W-1:0]     mul_x,
    output logic [W-1:0]     mul_y,
    input  logic [2*W-1:0]   mul_p,
    input  logic             mul_vld_out,
    output logic             busy,
    output logic             err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [IW-1:0] ptr;
    logic [IW-1:0] tags [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          pop;
    logic          credit;
    logic          grant;
    logic [IW-1:0] win;
    logic [IW:0]   cand;

    // A return frees its slot in the same cycle, so a full FIFO can still
    // accept a new grant when a product is popped.
    assign pop    = mul_vld_out && (count != '0);
    assign credit = (count < CW'(DEPTH)) || pop;
    assign busy   = (count != '0);

    // Round-robin search: scan N positions starting at ptr, wrapping modulo N.
    always_comb begin
        grant = 1'b0;
        win   = '0;
        cand  = '0;
        gnt   = '0;
        if (rst_n && credit) begin
            for (int unsigned k = 0; k < N; k++) begin
                cand = {1'b0, ptr} + (IW+1)'(k);
                if (cand >= (IW+1)'(N)) begin
                    cand = cand - (IW+1)'(N);
                end
                if (!grant && req[cand[IW-1:0]]) begin
                    grant = 1'b1;
                    win   = cand[IW-1:0];
                end
            end
        end
        if (grant) begin
            gnt[win] = 1'b1;
        end
    end

    // Tag storage has no reset; the pointers and the count decide validity.
    always_ff @(posedge clk) begin
        if (grant) begin
            tags[wr_ptr] <= win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            mul_vld_in <= 1'b0;
            mul_x      <= '0;
            mul_y      <= '0;
            rsp_vld    <= '0;
            rsp_p      <= '0;
            err        <= 1'b0;
        end else begin
            mul_vld_in <= grant;
            if (grant) begin
                mul_x  <= req_x[win*W +: W];
                mul_y  <= req_y[win*W +: W];
                ptr    <= (win == IW'(N - 1)) ? '0 : win + 1'b1;
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end

            rsp_vld <= '0;
            if (pop) begin
                rsp_vld <= N'(1) << tags[rd_ptr];
                rsp_p   <= mul_p;
                rd_ptr  <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end

            if (mul_vld_out && (count == '0)) begin
                err <= 1'b1;
            end

            case ({grant, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb. It includes a variable-latency
// multiplier model and a queue-based reference model of arbitration,
// ownership and response routing.
module tb_mul_share_arb;

    localparam int N     = 4;
    localparam int W     = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_x;
    logic [N*W-1:0]   req_y;
    logic [N-1:0]     gnt;
    logic [N-1:0]     rsp_vld;
    logic [2*W-1:0]   rsp_p;
    logic             mul_vld_in;
    logic [W-1:0]     mul_x;
    logic [W-1:0]     mul_y;
    logic [2*W-1:0]   mul_p;
    logic             mul_vld_out;
    logic             busy;
    logic             err;

    always #5 clk = ~clk;

    mul_share_arb #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_x(req_x), .req_y(req_y),
        .gnt(gnt), .rsp_vld(rsp_vld), .rsp_p(rsp_p),
        .mul_vld_in(mul_vld_in), .mul_x(mul_x), .mul_y(mul_y),
        .mul_p(mul_p), .mul_vld_out(mul_vld_out), .busy(busy), .err(err)
    );

    typedef struct { int tag; logic [2*W-1:0] p; } own_t;
    typedef struct { int due; logic [2*W-1:0] p; } mop_t;

    own_t eq[$];          // expected owners, oldest first
    mop_t mq[$];          // multiplier pipeline contents

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;
    logic spur = 1'b0;

    int             ptr_m;
    logic           exp_err;
    logic [N-1:0]   exp_rsp_vld;
    logic [2*W-1:0] exp_rsp_p;
    logic           exp_mvi;
    logic [W-1:0]   exp_mx;
    logic [W-1:0]   exp_my;
    logic [N-1:0]   gnt_seen;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        eq.delete();
        ptr_m       = 0;
        exp_err     = 1'b0;
        exp_rsp_vld = '0;
        exp_rsp_p   = '0;
        exp_mvi     = 1'b0;
        exp_mx      = '0;
        exp_my      = '0;
    endfunction

    // One clock cycle. The caller drives the requester inputs before calling.
    // The multiplier output is driven here, outputs are checked at negedge,
    // and the call returns 1 time unit after the next rising edge.
    task automatic tick();
        int win;
        bit pop_m;
        logic [N-1:0] g_exp;
        if (spur) begin
            mul_vld_out = 1'b1;
            mul_p = (2*W)'($urandom);
        end else if (mq.size() > 0 && mq[0].due == cyc) begin
            mul_vld_out = 1'b1;
            mul_p = mq[0].p;
            void'(mq.pop_front());
        end else begin
            mul_vld_out = 1'b0;
            mul_p = (2*W)'($urandom);
        end
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_gnt", gnt, 0);
            chk("rst_rsp_vld", rsp_vld, 0);
            chk("rst_rsp_p", rsp_p, 0);
            chk("rst_mul_vld_in", mul_vld_in, 0);
            chk("rst_mul_xy", {mul_x, mul_y}, 0);
            chk("rst_err", err, 0);
            chk("rst_busy", busy, 0);
            model_reset();
        end else begin
            chk("rsp_vld", rsp_vld, exp_rsp_vld);
            chk("rsp_p", rsp_p, exp_rsp_p);
            chk("mul_vld_in", mul_vld_in, exp_mvi);
            if (exp_mvi) chk("mul_xy", {mul_x, mul_y}, {exp_mx, exp_my});
            chk("err", err, exp_err);
            chk("busy", busy, eq.size() != 0);

            pop_m = mul_vld_out && (eq.size() > 0);
            if (mul_vld_out && eq.size() == 0) exp_err = 1'b1;
            win = -1;
            if (eq.size() < DEPTH || pop_m) begin
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && req[(ptr_m + k) % N]) win = (ptr_m + k) % N;
                end
            end
            g_exp = (win >= 0) ? (N'(1) << win) : '0;
            chk("gnt", gnt, g_exp);

            exp_rsp_vld = '0;
            if (pop_m) begin
                exp_rsp_vld = N'(1) << eq[0].tag;
                exp_rsp_p   = eq[0].p;
                void'(eq.pop_front());
            end
            exp_mvi = (win >= 0);
            if (win >= 0) begin
                exp_mx = req_x[win*W +: W];
                exp_my = req_y[win*W +: W];
                eq.push_back('{win, (2*W)'(exp_mx) * (2*W)'(exp_my)});
                ptr_m = (win + 1) % N;
            end
        end
        gnt_seen = gnt;
        @(posedge clk);
        #1;
        cyc++;
        if (mul_vld_in) mq.push_back('{cyc + lat, (2*W)'(mul_x) * (2*W)'(mul_y)});
    endtask

    task automatic apply_reset(int n, bit clear_mq);
        rst_n = 1'b0;
        req   = '0;
        if (clear_mq) mq.delete();
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] xs;
        logic [N*W-1:0] ys;
        logic [N-1:0]   exp_gnt;
        logic [2*W-1:0] exp_p;
    } vec_t;

    vec_t vec[6];
    int   glog[$];
    int   rlog_v[$];
    int   rlog_p[$];
    int   ngr;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Single requests starting from the reset pointer (requester 0 first).
        vec[0] = '{4'b0001, 16'h0002, 16'h0003, 4'b0001, 8'd6};
        vec[1] = '{4'b0110, 16'h00D0, 16'h0060, 4'b0010, 8'd78};
        vec[2] = '{4'b1000, 16'hF000, 16'hF000, 4'b1000, 8'd225};
        vec[3] = '{4'b1100, 16'h7000, 16'h7900, 4'b0100, 8'd0};
        vec[4] = '{4'b1010, 16'hE050, 16'h20B0, 4'b0010, 8'd55};
        vec[5] = '{4'b0000, 16'h1234, 16'h5678, 4'b0000, 8'd0};

        rst_n = 1'b0;
        req = '0; req_x = '0; req_y = '0;
        mul_vld_out = 1'b0; mul_p = '0;
        model_reset();
        gnt_seen = '0;
        @(posedge clk);
        #1;
        apply_reset(3, 1'b1);

        // Table-driven single requests with a 1-cycle multiplier.
        lat = 1;
        for (int v = 0; v < 6; v++) begin
            apply_reset(2, 1'b1);
            req = vec[v].req; req_x = vec[v].xs; req_y = vec[v].ys;
            tick();
            chk("tbl_gnt", gnt_seen, vec[v].exp_gnt);
            req = '0;
            tick();
            chk("tbl_rsp_early", rsp_vld, 0);
            tick();
            chk("tbl_rsp_vld", rsp_vld, vec[v].exp_gnt);
            chk("tbl_rsp_p", rsp_p, vec[v].exp_p);
            tick();
            chk("tbl_busy", busy, 0);
        end

        // Contention: all four requesting at once.
        apply_reset(2, 1'b1);
        req = 4'b1111; req_x = 16'h0FD2; req_y = 16'h9F63;
        glog.delete(); rlog_v.delete(); rlog_p.delete();
        for (int t = 0; t < 9; t++) begin
            tick();
            if (gnt_seen != 0) glog.push_back(int'(gnt_seen));
            req = req & ~gnt_seen;
            if (rsp_vld != 0) begin
                rlog_v.push_back(int'(rsp_vld));
                rlog_p.push_back(int'(rsp_p));
            end
        end
        chk("cont_ngnt", glog.size(), 4);
        chk("cont_nrsp", rlog_v.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < glog.size()) chk("cont_gnt_order", glog[k], 1 << k);
            if (k < rlog_v.size()) chk("cont_rsp_order", rlog_v[k], 1 << k);
        end
        if (rlog_p.size() == 4) begin
            chk("cont_p0", rlog_p[0], 6);
            chk("cont_p1", rlog_p[1], 78);
            chk("cont_p2", rlog_p[2], 225);
            chk("cont_p3", rlog_p[3], 0);
        end

        // Fairness: requesters 1 and 2 continuously high, reloaded each grant.
        apply_reset(2, 1'b1);
        req = 4'b0110;
        req_x = 16'($urandom); req_y = 16'($urandom);
        for (int t = 0; t < 8; t++) begin
            tick();
            chk("fair_gnt", gnt_seen, (t % 2 == 0) ? 4'b0010 : 4'b0100);
            for (int i = 0; i < N; i++) begin
                if (gnt_seen[i]) begin
                    req_x[i*W +: W] = W'($urandom);
                    req_y[i*W +: W] = W'($urandom);
                end
            end
        end
        req = '0;
        repeat (5) tick();
        chk("fair_busy", busy, 0);

        // Credit limit with a 10-cycle multiplier.
        lat = 10;
        apply_reset(2, 1'b1);
        req = 4'b1000; req_x = 16'($urandom); req_y = 16'($urandom);
        ngr = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (t <= 10 && gnt_seen != 0) ngr++;
            if (t == 7) begin
                chk("credit_blocked_gnt", gnt_seen, 0);
                chk("credit_busy", busy, 1);
            end
            if (t == 11) chk("credit_pop_gnt", gnt_seen, 4'b1000);
            if (gnt_seen[3]) begin
                req_x[3*W +: W] = W'($urandom);
                req_y[3*W +: W] = W'($urandom);
            end
        end
        chk("credit_ngrants", ngr, 4);
        req = '0;
        repeat (20) tick();
        chk("credit_drain_busy", busy, 0);

        // Spurious return while idle, then reset with operations in flight.
        lat = 4;
        apply_reset(2, 1'b1);
        tick();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        tick();
        chk("spur_err", err, 1);
        chk("spur_rsp", rsp_vld, 0);
        req = 4'b0011; req_x = 16'($urandom); req_y = 16'($urandom);
        tick();
        req[0] = 1'b0;
        tick();
        req = '0;
        tick();
        chk("midflight_busy", busy, 1);
        apply_reset(2, 1'b0);
        repeat (4) tick();
        chk("late_err", err, 1);
        chk("late_busy", busy, 0);

        // Randomized traffic across several multiplier latencies.
        for (int li = 0; li < 5; li++) begin
            case (li)
                0: lat = 1;
                1: lat = 2;
                2: lat = 3;
                3: lat = 5;
                default: lat = 8;
            endcase
            apply_reset(2, 1'b1);
            for (int t = 0; t < 150; t++) begin
                for (int i = 0; i < N; i++) begin
                    if (gnt_seen[i]) begin
                        req[i] = ($urandom_range(3) != 0);
                        req_x[i*W +: W] = W'($urandom);
                        req_y[i*W +: W] = W'($urandom);
                    end else if (!req[i] && $urandom_range(2) == 0) begin
                        req[i] = 1'b1;
                        req_x[i*W +: W] = W'($urandom);
                        req_y[i*W +: W] = W'($urandom);
                    end
                end
                tick();
            end
            req = '0;
            repeat (lat + 8) tick();
            chk("rand_drain_busy", busy, 0);
            chk("rand_err", err, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Shares one pipelined 4x4 multiplier between N requesters. The multiplier has ports vld_in, x, y, p and vld_out, and may have any latency.
- Picks a requester each cycle by round-robin and issues its operands to the multiplier.
- Records which requester owns each in-flight operation in an in-order tag FIFO, and routes each product back to that requester.
- Sits between the requesting datapath blocks and a single mul_addtree instance.

Parameters:
N, 4, number of requesters (2..8)
W, 4, operand width; product width is 2*W
DEPTH, 4, maximum outstanding multiplies (tag FIFO depth, power of 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N  per-requester request; held with operands until granted
req_x  input  N*W  flattened operand x; requester i uses bits [i*W +: W]
req_y  input  N*W  flattened operand y, same packing as req_x
gnt  output  N  one-hot grant, combinational, at most one bit set
rsp_vld  output  N  one-hot single-cycle response strobe
rsp_p  output  2W  product, valid while any rsp_vld bit is set
mul_vld_in  output  1  issue strobe to multiplier
mul_x  output  W  operand x to multiplier
mul_y  output  W  operand y to multiplier
mul_p  input  2W  product from multiplier
mul_vld_out  input  1  product valid from multiplier
busy  output  1  high while any multiply is outstanding
err  output  1  sticky flag: mul_vld_out received with no outstanding tag

Behaviour:
- Reset (async, rst_n=0): mul_vld_in, mul_x, mul_y, rsp_vld, rsp_p, err cleared to 0; tag FIFO emptied; outstanding count 0; round-robin pointer 0 (requester 0 highest priority). gnt is 0 while in reset.
- Credit: a grant is possible only when outstanding < DEPTH, or when outstanding == DEPTH and a pop happens in the same cycle.
- Arbitration (combinational):
  - Search starts at the pointer and wraps modulo N; the first requester with req set wins.
  - Pointer updates to (winner+1) mod N on the clock edge, and only on a grant.
  - If there is no credit, gnt=0 and the pointer holds.
- Requester contract: the handshake completes in the cycle gnt[i]=1. The requester either drops req or presents new operands on the next cycle.
- Issue (registered, 1 cycle):
  - On the edge after a grant: mul_vld_in=1, and mul_x/mul_y take the winner's operands.
  - The winner's index is pushed into the tag FIFO on that same edge.
  - Otherwise mul_vld_in=0 and mul_x/mul_y hold their last values.
  - Back-to-back grants give one issue every cycle.
- Return (registered, 1 cycle):
  - On mul_vld_out=1 with the FIFO non-empty: pop the head tag.
  - Next cycle: rsp_vld[tag]=1 and rsp_p=mul_p (captured value).
  - Otherwise rsp_vld=0 and rsp_p holds.
- Total latency from gnt to rsp_vld is L+2 cycles, where L is the multiplier's vld_in-to-vld_out latency. Responses come back in grant order.
- Spurious return: mul_vld_out with the FIFO empty sets err (sticky until reset). No pop and no rsp_vld.
- Outstanding count:
  - +1 on push, -1 on pop, unchanged when both happen in the same cycle.
  - busy = (count != 0).
  - The count never exceeds DEPTH.
- Multiplier assumption: it returns exactly one mul_vld_out per mul_vld_in, in order, with no backpressure. The block requires this.
- Reset mid-operation: all in-flight tags are discarded. Products arriving after reset release set err.
- Arithmetic: unsigned; rsp_p equals mul_p bit for bit, with no truncation.

Test Plan:
- Single request: after reset, req[0]=1, x=2, y=3 with a 1-cycle multiplier model -> gnt[0] in the same cycle; rsp_vld[0]=1 and rsp_p=8'd6 exactly 3 cycles after gnt; busy low afterwards.
- Contention: req=4'b1111 held with operands (2,3), (13,6), (15,15), (0,9) -> gnt sequence 0,1,2,3 on consecutive cycles; rsp_vld sequence 0,1,2,3 with rsp_p=6, 78, 225, 0.
- Fairness: req[1] and req[2] both continuously high, operands reloaded after each grant -> grants alternate 1,2,1,2; neither requester waits more than 1 cycle between grants.
- Credit limit: DEPTH=4 with a 10-cycle multiplier model, req[3] held high -> exactly 4 grants, then gnt=0 and busy=1. The first return plus the next request in the same cycle -> a grant in that cycle, and the count stays at 4.
- Spurious and reset: pulse mul_vld_out while idle -> err=1 and no rsp_vld. Issue 2 ops, assert rst_n=0 mid-flight -> all outputs 0 and err cleared. Late product after release -> err=1 and no rsp_vld.
